io_bus_router: RTL and testbench
================================

# io_bus_router

Parametrised IO-bus router between the core's memory-mapped IO master port and NUM_SLAVES IO cores (LED, timer, UART, VGA, …). It replaces fixed four-slot one-hot chip-select forwarding with three changes:
- The slot is decoded from the address.
- Slave strobes are registered.
- Reads use a valid handshake, so slaves may respond with variable latency.

A per-read timeout and error reporting for illegal accesses protect the core from hanging on a dead slave.

## Interface
- NUM_SLAVES, 4: number of IO slots (≥2).
- SLOT_LSB, 8: lowest address bit of the slot index. The slot index is m_address[SLOT_LSB +: SW], where SW = $clog2(NUM_SLAVES).
- TIMEOUT_CYCLES, 16: maximum number of RD_WAIT cycles before a read is aborted (≥1).
- clk  in  1: single clock, all logic on posedge.
- rst  in  1: synchronous, active-high reset.
- m_rd_en  in  1: master read request.
- m_wr_en  in  1: master write request.
- m_address  in  32: byte address.
- m_wr_data  in  32: write data.
- m_ready  out  1: router can accept a request this cycle.
- m_rd_data  out  32: read response data, meaningful when m_rd_valid is high.
- m_rd_valid  out  1: one-cycle read-response pulse.
- m_err  out  1: one-cycle error pulse.
- s_rd_en  out  1: registered read strobe to slaves.
- s_wr_en  out  1: registered write strobe to slaves.
- s_cs  out  NUM_SLAVES: registered one-hot chip select.
- s_address  out  32: registered address.
- s_wr_data  out  32: registered write data.
- s_rd_data  in  32*NUM_SLAVES: slave read data, slot i at bits [32*i +: 32].
- s_rd_valid  in  NUM_SLAVES: slave read-data valid, one bit per slot.

## Operation
- A request is accepted in a cycle where m_ready=1 and (m_rd_en | m_wr_en).
- FSM states: IDLE, RD_WAIT, RESP.
- m_ready=1 in IDLE and RESP, 0 in RD_WAIT, and 0 while rst is high.
- Slot decode on acceptance: slot = m_address[SLOT_LSB +: SW].
  - The slot is legal iff slot < NUM_SLAVES.
  - If NUM_SLAVES is not a power of two, out-of-range indices are illegal.
- Legal write: in the next cycle, s_wr_en=1, s_cs=onehot(slot), and s_address/s_wr_data are the captured values, for exactly one cycle.
  - The FSM stays in or returns to IDLE. Writes are posted, so back-to-back writes at one per cycle are allowed.
- Legal read: in the next cycle, s_rd_en=1 and s_cs=onehot(slot) for one cycle, and the FSM enters RD_WAIT.
  - Slot is held in sel_reg and the timeout counter is cleared.
- RD_WAIT, checked every cycle (including the strobe cycle):
  - If s_rd_valid[sel_reg] is high, capture s_rd_data[sel_reg] and go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES, capture 32'h0, set the error flag and go to RESP.
  - Valid bits of non-selected slots are ignored.
- RESP (one cycle): m_rd_valid=1, m_rd_data = captured value, m_err = error flag.
  - A new request may be accepted in this cycle. Next state is IDLE, or RD_WAIT if a legal read is accepted.
- Illegal accesses produce no slave strobe and s_cs stays 0.
  - Illegal slot, or m_rd_en & m_wr_en both high in the same cycle: treated as illegal.
  - Illegal write: m_err pulses in the next cycle and the FSM stays in IDLE.
  - Illegal read (including both-enables): goes directly to RESP next cycle with m_rd_data=0 and m_err=1.
- m_rd_data holds its last value outside RESP. The bench must only check it when m_rd_valid=1.

## Timing
- Reset:
  - State = IDLE, sel_reg=0, counter=0.
  - Cleared to 0: s_rd_en, s_wr_en, s_cs, s_address, s_wr_data, m_rd_valid, m_err, m_rd_data.
  - m_ready=1 from the first cycle after rst deasserts.
- Reset mid-read discards the transaction. No m_rd_valid is produced for it.
- Write latency: accept at T, slave strobe at T+1.
- Read latency:
  - Accept at T, s_rd_en at T+1.
  - If s_rd_valid arrives at cycle T+k (k≥1), m_rd_valid is at T+k+1.
  - The minimum read latency is 2 cycles.
- Timeout: with no valid, m_rd_valid and m_err occur at T+1+TIMEOUT_CYCLES.
- Throughput:
  - Writes: 1 per cycle.
  - Reads: one outstanding at a time. A new read can be accepted in the RESP cycle.
- The counter width is $clog2(TIMEOUT_CYCLES+1) and it never wraps.

## Test plan
- Reset, then write 0xA5A5_0001 to slot 1 (address 0x100): s_wr_en=1, s_cs=4'b0010, and s_wr_data=0xA5A5_0001 exactly one cycle later. m_ready stays 1.
- Read slot 2 with a slave asserting valid 3 cycles after the strobe, data 0x1234_5678: m_ready=0 during the wait, then m_rd_valid=1 with data 0x1234_5678 and m_err=0.
- Read slot 3 with the slave asserting valid in the strobe cycle: m_rd_valid at accept+2, and a back-to-back read accepted in the RESP cycle completes correctly. Spurious valid pulses on slots 0–2 during the wait are ignored.
- Read slot 0 with a slave that never responds (TIMEOUT_CYCLES=16): m_rd_valid=1, m_err=1, m_rd_data=0 at accept+17. The next request is accepted normally.
- With NUM_SLAVES=3, write to slot 3 and issue one request with m_rd_en and m_wr_en both high: no strobe, s_cs=0. The write produces an m_err pulse only; the dual-enable request produces m_rd_valid=1 with m_err=1.
- Assert rst during RD_WAIT: all outputs return to reset values, no m_rd_valid is produced, and m_ready=1 in the cycle after rst deasserts.

Source files
------------

// File: rtl/io_bus_router.sv
// IO-bus router: address-decoded slot select, registered slave strobes,
// valid-handshake reads with timeout and error reporting.
module io_bus_router #(
  parameter int NUM_SLAVES     = 4,
  parameter int SLOT_LSB       = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       m_rd_en,
  input  logic                       m_wr_en,
  input  logic [31:0]                m_address,
  input  logic [31:0]                m_wr_data,
  output logic                       m_ready,
  output logic [31:0]                m_rd_data,
  output logic                       m_rd_valid,
  output logic                       m_err,
  output logic                       s_rd_en,
  output logic                       s_wr_en,
  output logic [NUM_SLAVES-1:0]      s_cs,
  output logic [31:0]                s_address,
  output logic [31:0]                s_wr_data,
  input  logic [32*NUM_SLAVES-1:0]   s_rd_data,
  input  logic [NUM_SLAVES-1:0]      s_rd_valid
);

  localparam int SW = $clog2(NUM_SLAVES);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned NS = NUM_SLAVES;
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);
  localparam logic [NUM_SLAVES-1:0] ONE = NUM_SLAVES'(1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

  state_t        state;
  logic [SW-1:0] sel_reg;
  logic [SW-1:0] slot;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          accept;
  logic          legal;
  logic          sel_valid;
  logic [31:0]   sel_data;

  assign m_ready   = !rst && (state != RD_WAIT);
  assign accept    = m_ready && (m_rd_en || m_wr_en);
  assign slot      = m_address[SLOT_LSB +: SW];
  assign legal     = (32'(slot) < NS) && !(m_rd_en && m_wr_en);
  assign sel_valid = s_rd_valid[sel_reg];
  assign sel_data  = s_rd_data[32*sel_reg +: 32];
  assign cnt_nxt   = cnt + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sel_reg    <= '0;
      cnt        <= '0;
      s_rd_en    <= 1'b0;
      s_wr_en    <= 1'b0;
      s_cs       <= '0;
      s_address  <= '0;
      s_wr_data  <= '0;
      m_rd_valid <= 1'b0;
      m_err      <= 1'b0;
      m_rd_data  <= '0;
    end else begin
      s_rd_en    <= 1'b0;
      s_wr_en    <= 1'b0;
      s_cs       <= '0;
      m_rd_valid <= 1'b0;
      m_err      <= 1'b0;
      unique case (state)
        RD_WAIT: begin
          if (sel_valid) begin
            m_rd_data  <= sel_data;
            m_rd_valid <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt_nxt;
            // counter stops at the limit; a new read clears it
            if (cnt_nxt == TMO) begin
              m_rd_data  <= '0;
              m_rd_valid <= 1'b1;
              m_err      <= 1'b1;
              state      <= RESP;
            end
          end
        end
        default: begin
          state <= IDLE;
          if (accept) begin
            if (legal) begin
              s_cs      <= ONE << slot;
              s_address <= m_address;
              if (m_wr_en) begin
                s_wr_en   <= 1'b1;
                s_wr_data <= m_wr_data;
              end else begin
                s_rd_en <= 1'b1;
                sel_reg <= slot;
                cnt     <= '0;
                state   <= RD_WAIT;
              end
            end else if (m_rd_en) begin
              m_rd_data  <= '0;
              m_rd_valid <= 1'b1;
              m_err      <= 1'b1;
              state      <= RESP;
            end else begin
              m_err <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_router.sv
// Directed bench for io_bus_router: a 4-slot instance and a 3-slot
// instance for illegal-slot decoding.
module tb_io_bus_router;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic         a_rd_en, a_wr_en;
  logic [31:0]  a_addr, a_wdata;
  logic         a_ready, a_rvalid, a_err;
  logic [31:0]  a_rdata;
  logic         a_srd, a_swr;
  logic [3:0]   a_cs;
  logic [31:0]  a_saddr, a_swdata;
  logic [127:0] a_srdata;
  logic [3:0]   a_svalid;

  logic         b_rd_en, b_wr_en;
  logic [31:0]  b_addr, b_wdata;
  logic         b_ready, b_rvalid, b_err;
  logic [31:0]  b_rdata;
  logic         b_srd, b_swr;
  logic [2:0]   b_cs;
  logic [31:0]  b_saddr, b_swdata;
  logic [95:0]  b_srdata;
  logic [2:0]   b_svalid;

  io_bus_router #(.NUM_SLAVES(4), .SLOT_LSB(8), .TIMEOUT_CYCLES(16)) dut_a (
    .clk(clk), .rst(rst),
    .m_rd_en(a_rd_en), .m_wr_en(a_wr_en),
    .m_address(a_addr), .m_wr_data(a_wdata),
    .m_ready(a_ready), .m_rd_data(a_rdata),
    .m_rd_valid(a_rvalid), .m_err(a_err),
    .s_rd_en(a_srd), .s_wr_en(a_swr), .s_cs(a_cs),
    .s_address(a_saddr), .s_wr_data(a_swdata),
    .s_rd_data(a_srdata), .s_rd_valid(a_svalid)
  );

  io_bus_router #(.NUM_SLAVES(3), .SLOT_LSB(8), .TIMEOUT_CYCLES(16)) dut_b (
    .clk(clk), .rst(rst),
    .m_rd_en(b_rd_en), .m_wr_en(b_wr_en),
    .m_address(b_addr), .m_wr_data(b_wdata),
    .m_ready(b_ready), .m_rd_data(b_rdata),
    .m_rd_valid(b_rvalid), .m_err(b_err),
    .s_rd_en(b_srd), .s_wr_en(b_swr), .s_cs(b_cs),
    .s_address(b_saddr), .s_wr_data(b_swdata),
    .s_rd_data(b_srdata), .s_rd_valid(b_svalid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    a_rd_en = 0; a_wr_en = 0; a_addr = 0; a_wdata = 0;
    a_srdata = '0; a_svalid = '0;
    b_rd_en = 0; b_wr_en = 0; b_addr = 0; b_wdata = 0;
    b_srdata = '0; b_svalid = '0;
    tick();
    tick();

    chk("rst_ready", a_ready, 0);
    chk("rst_cs", a_cs, 0);
    chk("rst_rvalid", a_rvalid, 0);
    chk("rst_err", a_err, 0);
    chk("rst_rdata", a_rdata, 0);
    chk("rst_strobes", {a_srd, a_swr}, 0);
    chk("rst_saddr", a_saddr, 0);
    chk("rst_b_ready", b_ready, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", a_ready, 1);
    chk("post_rst_b_ready", b_ready, 1);

    // write slot 1
    a_wr_en = 1; a_addr = 32'h100; a_wdata = 32'hA5A5_0001;
    chk("wr_ready", a_ready, 1);
    tick();
    a_wr_en = 0;
    chk("wr_swr", a_swr, 1);
    chk("wr_srd", a_srd, 0);
    chk("wr_cs", a_cs, 4'b0010);
    chk("wr_wdata", a_swdata, 32'hA5A5_0001);
    chk("wr_saddr", a_saddr, 32'h100);
    chk("wr_ready2", a_ready, 1);
    chk("wr_err", a_err, 0);
    tick();
    chk("wr_swr_off", a_swr, 0);
    chk("wr_cs_off", a_cs, 0);

    // read slot 2, valid 3 cycles after the strobe
    a_rd_en = 1; a_addr = 32'h200;
    a_srdata[64 +: 32] = 32'h1234_5678;
    tick();
    a_rd_en = 0;
    chk("rd2_srd", a_srd, 1);
    chk("rd2_cs", a_cs, 4'b0100);
    chk("rd2_ready_t1", a_ready, 0);
    tick();
    chk("rd2_srd_off", a_srd, 0);
    chk("rd2_ready_t2", a_ready, 0);
    tick();
    chk("rd2_ready_t3", a_ready, 0);
    tick();
    a_svalid = 4'b0100;
    chk("rd2_ready_t4", a_ready, 0);
    chk("rd2_rvalid_t4", a_rvalid, 0);
    tick();
    a_svalid = 4'b0000;
    chk("rd2_rvalid", a_rvalid, 1);
    chk("rd2_rdata", a_rdata, 32'h1234_5678);
    chk("rd2_err", a_err, 0);
    chk("rd2_ready_resp", a_ready, 1);
    tick();
    chk("rd2_rvalid_off", a_rvalid, 0);

    // read slot 3 with valid in the strobe cycle, then back-to-back read
    a_rd_en = 1; a_addr = 32'h300;
    a_srdata = {32'hCAFE_0003, 32'h2222_0002, 32'hBEEF_0001, 32'h0000_0F00};
    tick();
    a_rd_en = 0;
    a_svalid = 4'b1000;
    chk("rd3_srd", a_srd, 1);
    chk("rd3_cs", a_cs, 4'b1000);
    tick();
    a_svalid = 4'b0000;
    chk("rd3_rvalid", a_rvalid, 1);
    chk("rd3_rdata", a_rdata, 32'hCAFE_0003);
    chk("rd3_err", a_err, 0);
    chk("rd3_ready_resp", a_ready, 1);
    a_rd_en = 1; a_addr = 32'h104;
    tick();
    a_rd_en = 0;
    a_svalid = 4'b0101;
    chk("b2b_srd", a_srd, 1);
    chk("b2b_cs", a_cs, 4'b0010);
    chk("b2b_rvalid_t1", a_rvalid, 0);
    chk("b2b_saddr", a_saddr, 32'h104);
    tick();
    a_svalid = 4'b0010;
    chk("b2b_spurious", a_rvalid, 0);
    chk("b2b_ready_wait", a_ready, 0);
    tick();
    a_svalid = 4'b0000;
    chk("b2b_rvalid", a_rvalid, 1);
    chk("b2b_rdata", a_rdata, 32'hBEEF_0001);
    chk("b2b_err", a_err, 0);

    // read slot 0, slave never answers
    a_rd_en = 1; a_addr = 32'h000;
    tick();
    a_rd_en = 0;
    chk("to_srd", a_srd, 1);
    chk("to_cs", a_cs, 4'b0001);
    for (int i = 2; i <= 16; i++) begin
      chk("to_rvalid_wait", a_rvalid, 0);
      tick();
    end
    chk("to_rvalid_t16", a_rvalid, 0);
    chk("to_ready_t16", a_ready, 0);
    tick();
    chk("to_rvalid", a_rvalid, 1);
    chk("to_err", a_err, 1);
    chk("to_rdata", a_rdata, 0);
    chk("to_ready_resp", a_ready, 1);
    a_wr_en = 1; a_addr = 32'h208; a_wdata = 32'h0000_0055;
    tick();
    a_wr_en = 0;
    chk("to_next_swr", a_swr, 1);
    chk("to_next_cs", a_cs, 4'b0100);
    chk("to_next_wdata", a_swdata, 32'h55);
    chk("to_next_err", a_err, 0);
    chk("to_next_rvalid", a_rvalid, 0);

    // 3-slot instance: legal read first so rd_data is nonzero
    b_rd_en = 1; b_addr = 32'h100;
    b_srdata[32 +: 32] = 32'h0000_0077;
    tick();
    b_rd_en = 0;
    b_svalid = 3'b010;
    chk("b_rd_cs", b_cs, 3'b010);
    tick();
    b_svalid = 3'b000;
    chk("b_rd_rvalid", b_rvalid, 1);
    chk("b_rd_rdata", b_rdata, 32'h77);
    tick();
    b_wr_en = 1; b_addr = 32'h300; b_wdata = 32'hDEAD_BEEF;
    tick();
    b_wr_en = 0;
    chk("b_ilw_swr", b_swr, 0);
    chk("b_ilw_cs", b_cs, 0);
    chk("b_ilw_err", b_err, 1);
    chk("b_ilw_rvalid", b_rvalid, 0);
    chk("b_ilw_ready", b_ready, 1);
    tick();
    chk("b_ilw_err_off", b_err, 0);
    b_rd_en = 1; b_wr_en = 1; b_addr = 32'h100;
    tick();
    b_rd_en = 0; b_wr_en = 0;
    chk("b_dual_strobes", {b_srd, b_swr}, 0);
    chk("b_dual_cs", b_cs, 0);
    chk("b_dual_rvalid", b_rvalid, 1);
    chk("b_dual_err", b_err, 1);
    chk("b_dual_rdata", b_rdata, 0);
    tick();
    chk("b_dual_rvalid_off", b_rvalid, 0);

    // reset during RD_WAIT
    a_rd_en = 1; a_addr = 32'h100;
    tick();
    a_rd_en = 0;
    chk("mr_srd", a_srd, 1);
    tick();
    rst = 1'b1;
    a_svalid = 4'b0010;
    chk("mr_ready_in_rst", a_ready, 0);
    tick();
    chk("mr_rvalid", a_rvalid, 0);
    chk("mr_cs", a_cs, 0);
    chk("mr_saddr", a_saddr, 0);
    chk("mr_swdata", a_swdata, 0);
    chk("mr_err", a_err, 0);
    rst = 1'b0;
    a_svalid = 4'b0000;
    tick();
    chk("mr_ready_after", a_ready, 1);
    chk("mr_rvalid_after", a_rvalid, 0);
    tick();
    chk("mr_rvalid_after2", a_rvalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
